game_sequencer: RTL
===================

# game_sequencer

Top-level controller for the game board. It runs NUM_GAMES mini-games in order and selects which one is active, holding the others in reset. It owns the shared 4-digit 7-segment display bus and the round counter fed to the active game. Between games it shows intro, win and fail screens, and it flags completion once every game has been won.

## Interface
- NUM_GAMES, 3: number of game modules sequenced (2..7).
- HOLD_CYCLES, 50_000_000: clk cycles each WIN/FAIL screen is held.
- INTRO_CYCLES, 25_000_000: clk cycles the INTRO screen is held.
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; leaves IDLE or DONE.
- round_win  in  1  single-cycle pulse; player completed a round of the active game.
- round_fail  in  1  single-cycle pulse; player failed a round of the active game.
- game_bits  in  20*NUM_GAMES  display words from the games; game i occupies bits [20*i+19:20*i].
- game_victory  in  NUM_GAMES  victory flag from each game.
- game_sel  out  3  index of the active game.
- game_counter  out  3  rounds won in the current game; routed to all games.
- game_reset_n  out  NUM_GAMES  per-game active-low reset.
- disp_bits  out  20  display word to the 7-seg driver.
- all_done  out  1  high while in DONE.

## Operation
- Display word: digit 1 (leftmost) is [19:15], digit 4 is [4:0]. Each digit is a 5-bit code: 0-9 are numerals, 5'b10000 is '-', 5'b11111 is blank.
- States: IDLE, INTRO, PLAY, WIN, FAIL, DONE. All outputs come from registers.
- IDLE: disp_bits = blank,-,-,blank (20'b11111100001000011111). game_sel=0, game_counter=0, all game_reset_n low. start -> INTRO.
- INTRO: disp_bits = blank,-,(game_sel+1),-. The selected game's reset is held low and game_counter is cleared to 0. After INTRO_CYCLES -> PLAY.
- PLAY: disp_bits = game_bits slice [game_sel]. game_reset_n[game_sel]=1 and all others 0.
  - round_win increments game_counter, saturating at 7.
  - round_fail -> FAIL.
  - game_victory[game_sel]=1 -> WIN.
  - Priority: round_fail > game_victory > round_win. If round_fail and round_win arrive in the same cycle, the counter is not incremented.
- WIN: disp_bits = (game_sel+1) on all four digits. The selected game stays out of reset. After HOLD_CYCLES: if game_sel == NUM_GAMES-1 -> DONE; otherwise game_sel+1 -> INTRO.
- FAIL: disp_bits = four '-' (20'b10000100001000010000). The selected game is held in reset and game_counter is cleared. After HOLD_CYCLES -> INTRO with the same game_sel.
- DONE: disp_bits = 8,8,8,8. all_done=1 and all games are held in reset. start -> IDLE-equivalent reinit: game_sel=0, game_counter=0, next state INTRO.
- start is ignored in INTRO, PLAY, WIN and FAIL. round_win and round_fail are ignored outside PLAY.
- Hold timer: a single 32-bit down-counter. It is loaded on entry to INTRO, WIN or FAIL, and the state exits on the cycle the counter reads 1. A parameter value of 0 is treated as 1.

## Timing
- Reset (reset_n low at a clk edge) goes to IDLE from any state, including mid-hold.
- Reset values: disp_bits = 20'b11111100001000011111, game_sel=0, game_counter=0, game_reset_n all 0, all_done=0, timer=0.
- Latency from input to output is 1 cycle:
  - start sampled at edge N -> state and disp_bits change at edge N+1.
  - round_win at edge N -> game_counter updated at edge N+1.
- PLAY display is a registered mux, so disp_bits lags game_bits by 1 cycle.
- INTRO lasts exactly INTRO_CYCLES cycles and WIN/FAIL last exactly HOLD_CYCLES cycles, counted from the first cycle the state is visible on outputs.
- game_reset_n for the next game rises on the first PLAY cycle. It is low for at least INTRO_CYCLES beforehand.

## Test plan
All scenarios use NUM_GAMES=3, HOLD_CYCLES=4, INTRO_CYCLES=2.
- Reset then idle: reset_n low 2 cycles, release, no start -> disp_bits=20'b11111100001000011111, game_reset_n=3'b000, all_done=0, steady.
- Start: start pulse -> next cycle disp_bits=blank,-,1,- for 2 cycles. Then PLAY with game_reset_n=3'b001, and disp_bits tracks game_bits[19:0] one cycle late.
- Round counting: 9 round_win pulses in PLAY -> game_counter 1..7, then holds at 7. round_win and round_fail in the same cycle -> counter unchanged and FAIL entered.
- Fail retry: round_fail at game_counter=2 -> four '-' for 4 cycles, game_counter=0, then INTRO with game_sel unchanged.
- Full run: assert game_victory[i] in each PLAY -> WIN shows 1111, 2222, 3333 for 4 cycles each, then DONE with all_done=1 and disp_bits=8888. start -> INTRO with game_sel=0.
- Reset mid-WIN: reset_n low on the 2nd WIN cycle -> next cycle all outputs are at their reset values; a following start begins at game 0.

Source files
------------

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//
// Top-level controller for the game board. Runs NUM_GAMES mini-games in order,
// releasing only the active game from reset, and owns the shared 4-digit
// 7-segment display word. Between games it shows intro, win and fail screens,
// and it raises all_done once every game has been won.
//
// Parameters
//   NUM_GAMES     number of game modules sequenced (2..7)
//   HOLD_CYCLES   clk cycles each WIN/FAIL screen is held (0 behaves as 1)
//   INTRO_CYCLES  clk cycles the INTRO screen is held (0 behaves as 1)
//
// Ports
//   clk           system clock
//   reset_n       synchronous, active-low reset
//   start         single-cycle pulse, leaves IDLE or DONE
//   round_win     single-cycle pulse, round won in the active game
//   round_fail    single-cycle pulse, round failed in the active game
//   game_bits     display words from the games, game i at [20*i+19:20*i]
//   game_victory  victory flag from each game
//   game_sel      index of the active game
//   game_counter  rounds won in the current game (saturates at 7)
//   game_reset_n  per-game active-low reset
//   disp_bits     display word to the 7-seg driver, digit 1 at [19:15]
//   all_done      high while every game has been won
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int unsigned NUM_GAMES    = 3,
    parameter int unsigned HOLD_CYCLES  = 50_000_000,
    parameter int unsigned INTRO_CYCLES = 25_000_000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      round_win,
    input  logic                      round_fail,
    input  logic [20*NUM_GAMES-1:0]   game_bits,
    input  logic [NUM_GAMES-1:0]      game_victory,
    output logic [2:0]                game_sel,
    output logic [2:0]                game_counter,
    output logic [NUM_GAMES-1:0]      game_reset_n,
    output logic [19:0]               disp_bits,
    output logic                      all_done
);

    localparam logic [4:0]  DIG_DASH   = 5'b10000;
    localparam logic [4:0]  DIG_BLANK  = 5'b11111;
    localparam logic [4:0]  DIG_EIGHT  = 5'd8;
    localparam logic [19:0] DISP_IDLE  = {DIG_BLANK, DIG_DASH, DIG_DASH, DIG_BLANK};
    localparam logic [19:0] DISP_FAIL  = {4{DIG_DASH}};
    localparam logic [19:0] DISP_DONE  = {4{DIG_EIGHT}};
    localparam logic [19:0] DISP_BLANK = {4{DIG_BLANK}};

    // A zero hold length would never reach the exit value of 1, so clamp it.
    localparam logic [31:0] INTRO_LOAD = (INTRO_CYCLES == 0) ? 32'd1 : 32'(INTRO_CYCLES);
    localparam logic [31:0] HOLD_LOAD  = (HOLD_CYCLES == 0)  ? 32'd1 : 32'(HOLD_CYCLES);
    localparam logic [2:0]  LAST_GAME  = 3'(NUM_GAMES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INTRO,
        ST_PLAY,
        ST_WIN,
        ST_FAIL,
        ST_DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [2:0]             sel_next;
    logic [2:0]             counter_next;
    logic [31:0]            timer;
    logic [31:0]            timer_next;
    logic [19:0]            disp_next;
    logic [NUM_GAMES-1:0]   game_reset_n_next;
    logic                   all_done_next;
    logic [19:0]            slices [8];
    logic [7:0]             victory_ext;
    logic                   hold_expired;
    logic [4:0]             sel_digit;

    // Pad the per-game words and flags out to the full 3-bit select range so
    // indexing with game_sel never needs a width-adjusted index.
    for (genvar i = 0; i < 8; i++) begin : g_slice
        if (i < NUM_GAMES) begin : g_used
            assign slices[i] = game_bits[20*i +: 20];
        end else begin : g_unused
            assign slices[i] = DISP_BLANK;
        end
    end

    assign victory_ext  = 8'(game_victory);
    assign hold_expired = (timer == 32'd1);

    // Next-state logic. The hold timer is loaded on every transition into
    // INTRO, WIN or FAIL so the new state is visible for exactly the load
    // count, and the state leaves on the cycle the timer reads 1.
    always_comb begin
        state_next   = state;
        sel_next     = game_sel;
        counter_next = game_counter;
        timer_next   = timer;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_INTRO;
                    sel_next     = 3'd0;
                    counter_next = 3'd0;
                    timer_next   = INTRO_LOAD;
                end
            end

            ST_INTRO: begin
                counter_next = 3'd0;
                if (hold_expired) begin
                    state_next = ST_PLAY;
                    timer_next = 32'd0;
                end else begin
                    timer_next = timer - 32'd1;
                end
            end

            // Fail beats victory beats a counted round.
            ST_PLAY: begin
                if (round_fail) begin
                    state_next   = ST_FAIL;
                    counter_next = 3'd0;
                    timer_next   = HOLD_LOAD;
                end else if (victory_ext[game_sel]) begin
                    state_next = ST_WIN;
                    timer_next = HOLD_LOAD;
                end else if (round_win && (game_counter != 3'd7)) begin
                    counter_next = game_counter + 3'd1;
                end
            end

            ST_WIN: begin
                if (hold_expired) begin
                    if (game_sel == LAST_GAME) begin
                        state_next = ST_DONE;
                        timer_next = 32'd0;
                    end else begin
                        state_next   = ST_INTRO;
                        sel_next     = game_sel + 3'd1;
                        counter_next = 3'd0;
                        timer_next   = INTRO_LOAD;
                    end
                end else begin
                    timer_next = timer - 32'd1;
                end
            end

            ST_FAIL: begin
                counter_next = 3'd0;
                if (hold_expired) begin
                    state_next = ST_INTRO;
                    timer_next = INTRO_LOAD;
                end else begin
                    timer_next = timer - 32'd1;
                end
            end

            ST_DONE: begin
                if (start) begin
                    state_next   = ST_INTRO;
                    sel_next     = 3'd0;
                    counter_next = 3'd0;
                    timer_next   = INTRO_LOAD;
                end
            end

            default: begin
                state_next   = ST_IDLE;
                sel_next     = 3'd0;
                counter_next = 3'd0;
                timer_next   = 32'd0;
            end
        endcase
    end

    // Output decode works from the upcoming state so that every output is a
    // plain register and changes on the same edge as the state itself.
    always_comb begin
        disp_next         = DISP_IDLE;
        game_reset_n_next = '0;
        all_done_next     = 1'b0;
        sel_digit         = {2'b00, sel_next} + 5'd1;

        unique case (state_next)
            ST_IDLE: begin
                disp_next = DISP_IDLE;
            end
            ST_INTRO: begin
                disp_next = {DIG_BLANK, DIG_DASH, sel_digit, DIG_DASH};
            end
            ST_PLAY: begin
                disp_next = slices[sel_next];
                for (int i = 0; i < int'(NUM_GAMES); i++) begin
                    game_reset_n_next[i] = (3'(i) == sel_next);
                end
            end
            ST_WIN: begin
                disp_next = {4{sel_digit}};
                for (int i = 0; i < int'(NUM_GAMES); i++) begin
                    game_reset_n_next[i] = (3'(i) == sel_next);
                end
            end
            ST_FAIL: begin
                disp_next = DISP_FAIL;
            end
            ST_DONE: begin
                disp_next     = DISP_DONE;
                all_done_next = 1'b1;
            end
            default: begin
                disp_next = DISP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            game_sel     <= 3'd0;
            game_counter <= 3'd0;
            timer        <= 32'd0;
            disp_bits    <= DISP_IDLE;
            game_reset_n <= '0;
            all_done     <= 1'b0;
        end else begin
            state        <= state_next;
            game_sel     <= sel_next;
            game_counter <= counter_next;
            timer        <= timer_next;
            disp_bits    <= disp_next;
            game_reset_n <= game_reset_n_next;
            all_done     <= all_done_next;
        end
    end

endmodule
